// File: rtl/program_counter_pkg.sv
// Shared processor definitions: address width, address type and the PC reset vector.
package program_counter_pkg;

   localparam int unsigned ADDR_WIDTH = 16;

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   localparam addr_t RESET_VECTOR = 16'd0;

   // Next-value source for the PC register; load outranks increment.
   typedef enum logic [1:0] {
      PC_SEL_HOLD = 2'd0,
      PC_SEL_INC  = 2'd1,
      PC_SEL_LOAD = 2'd2
   } pc_sel_e;

endpackage : program_counter_pkg

// File: rtl/program_counter.sv
// Program counter: load / increment / hold, driving the instruction-memory address bus.
module program_counter
   import program_counter_pkg::*;
#(
   parameter int unsigned      WIDTH        = ADDR_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(program_counter_pkg::RESET_VECTOR),
   parameter int unsigned      INC_STEP     = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             write_en,
   input  logic             inc,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   localparam logic [WIDTH-1:0] STEP = WIDTH'(INC_STEP);

   pc_sel_e          sel_d;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_q;

   always_comb begin
      sel_d = PC_SEL_HOLD;
      if (write_en) begin
         sel_d = PC_SEL_LOAD;
      end else if (inc) begin
         sel_d = PC_SEL_INC;
      end
   end

   // Increment wraps silently at the top of the address space.
   always_comb begin
      pc_d = pc_q;
      unique case (sel_d)
         PC_SEL_LOAD: pc_d = data_in;
         PC_SEL_INC:  pc_d = pc_q + STEP;
         default:     pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign data_out = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed vectors queue expected PC values, a monitor checks them.
module tb_program_counter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        write_en = 1'b0;
   logic        inc = 1'b0;
   logic [15:0] data_in = 16'd0;
   logic [15:0] data_out;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   logic [15:0] shadow;

   program_counter dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .write_en (write_en),
      .inc      (inc),
      .data_in  (data_in),
      .data_out (data_out)
   );

   always #5 clock = ~clock;

   // Independent reference register with the same priority rules.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n)      shadow <= 16'd0;
      else if (write_en) shadow <= data_in;
      else if (inc)      shadow <= shadow + 16'd1;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: data_out=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step(input string name, input logic rst, input logic we, input logic in_c,
                       input logic [15:0] din, input logic [15:0] exp);
      sb_entry_t e;
      @(negedge clock);
      reset_n  = rst;
      write_en = we;
      inc      = in_c;
      data_in  = din;
      e.name   = name;
      e.exp    = exp;
      sb_q.push_back(e);
   endtask

   // Monitor: one registered result per rising edge.
   initial begin
      sb_entry_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, data_out, e.exp);
            check({e.name, "_model"}, data_out, shadow);
         end
      end
   end

   initial begin
      int wait_cycles;
      #1;
      check("reset_async_initial", data_out, 16'd0);

      for (int i = 0; i < 4; i++) begin
         step("reset_hold", 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
              16'($urandom), 16'd0);
      end

      for (int i = 0; i < 5; i++) step("load_hold", 1'b1, 1'b1 & 1'b1, 1'b0, 16'd2, 16'd2);
      for (int i = 0; i < 10; i++) step("increment", 1'b1, 1'b0, 1'b1, 16'd2, 16'(3 + i));
      for (int i = 0; i < 5; i++) step("ignore_din", 1'b1, 1'b0, 1'b1, 16'd8, 16'(13 + i));
      for (int i = 0; i < 3; i++) step("load_priority", 1'b1, 1'b1, 1'b1, 16'd8, 16'd8);
      for (int i = 0; i < 2; i++) step("hold", 1'b1, 1'b0, 1'b0, 16'd8, 16'd8);

      step("load_fffe", 1'b1, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE);
      step("inc_ffff",  1'b1, 1'b0, 1'b1, 16'h1234, 16'hFFFF);
      step("wrap_zero", 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000);
      step("post_wrap", 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0001);
      step("post_wrap", 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0002);
      step("post_wrap", 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0003);

      // Asynchronous reset pulse between edges during an increment run.
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check("reset_async_midrun", data_out, 16'd0);
      step("resume_1", 1'b1, 1'b0, 1'b1, 16'h0000, 16'd1);
      step("resume_2", 1'b1, 1'b0, 1'b1, 16'h0000, 16'd2);

      // Reset held across an edge overrides a pending load.
      step("reset_over_load", 1'b0, 1'b1, 1'b1, 16'h5555, 16'd0);
      step("after_reset_inc", 1'b1, 1'b0, 1'b1, 16'h5555, 16'd1);
      step("after_reset_load", 1'b1, 1'b1, 1'b0, 16'hA5A5, 16'hA5A5);

      @(negedge clock);
      write_en = 1'b0;
      inc      = 1'b0;
      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 20) begin
         @(negedge clock);
         wait_cycles++;
      end
      if (sb_q.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   a_reset_value: assert property (@(posedge clock) !reset_n |-> data_out == 16'd0);
   a_load_prio:   assert property (@(posedge clock) disable iff (!reset_n)
                                   write_en |=> data_out == $past(data_in));
   a_wrap:        assert property (@(posedge clock) disable iff (!reset_n)
                                   (inc && !write_en && data_out == 16'hFFFF) |=> data_out == 16'h0000);
   a_no_x_out:    assert property (@(posedge clock) reset_n |-> !$isunknown(data_out));
   a_no_x_ctrl:   assert property (@(posedge clock) reset_n |-> !$isunknown({write_en, inc}));

endmodule : tb_program_counter
